// File: rtl/video_capture_pkg.sv
// video_capture_pkg: shared types and constants for the capture path.
// Colour field layout, stage-1 bundle and capture FSM encoding.
package video_capture_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } cap_state_t;

  localparam int COLOR_W = 36;
  localparam int FIELD_W = 12;
  localparam int C0_MSB  = 35;
  localparam int C2_MSB  = 23;
  localparam int C1_MSB  = 11;

  typedef struct packed {
    logic               en;
    logic               de;
    logic               hs_n;
    logic               vs_n;
    logic [COLOR_W-1:0] color;
  } vid_s1_t;

  function automatic logic field_mixed(
    input logic [FIELD_W-1:0] f
  );
    return !((&f) || !(|f));
  endfunction

endpackage

// File: rtl/video_color_decode.sv
// video_color_decode: 36-bit replicated colour back to VRAM_BPP bits.
// Takes each field's MSB and flags any field that is not all-0/all-1.
module video_color_decode
  import video_capture_pkg::*;
#(
  parameter int VRAM_BPP = 3
) (
  input  logic [COLOR_W-1:0]  color,
  output logic [VRAM_BPP-1:0] data,
  output logic                mixed
);

  logic [FIELD_W-1:0] f0;
  logic [FIELD_W-1:0] f1;
  logic [FIELD_W-1:0] f2;

  assign f0 = color[C0_MSB -: FIELD_W];
  assign f2 = color[C2_MSB -: FIELD_W];
  assign f1 = color[C1_MSB -: FIELD_W];

  assign data = VRAM_BPP'({
    f2[FIELD_W-1],
    f1[FIELD_W-1],
    f0[FIELD_W-1]
  });

  assign mixed = field_mixed(f0)
               | field_mixed(f1)
               | field_mixed(f2);

endmodule

// File: rtl/video_capture.sv
// video_capture: DE/sync/colour stream into a framebuffer write port.
// Two-stage sampling, sync edge detect, raster counters and capture FSM.
module video_capture
  import video_capture_pkg::*;
#(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int VRAM_BPP = 3,
  parameter int ADDR_W   = 19
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  input  logic                video_de,
  input  logic                video_hsyncn,
  input  logic                video_vsyncn,
  input  logic [COLOR_W-1:0]  video_color,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [VRAM_BPP-1:0] wr_data,
  output logic                frame_start,
  output logic                frame_done,
  output logic                line_err,
  output logic                pix_err,
  output logic                locked
);

  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int CW = $clog2(WIDTH + 2);

  localparam logic [XW-1:0] X_END = XW'(WIDTH);
  localparam logic [YW-1:0] Y_END = YW'(HEIGHT);
  localparam logic [CW-1:0] C_LINE = CW'(WIDTH);
  localparam logic [CW-1:0] C_MAX = CW'(WIDTH + 1);
  localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(WIDTH);

  vid_s1_t s1;
  logic    s2_hs_n;
  logic    s2_vs_n;

  logic [VRAM_BPP-1:0] dec_data;
  logic                dec_mixed;

  cap_state_t state;
  cap_state_t state_d;

  logic [XW-1:0]     x;
  logic [XW-1:0]     x_d;
  logic [YW-1:0]     y;
  logic [YW-1:0]     y_d;
  logic [YW-1:0]     y_fin;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_d;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] base_d;
  logic              bad;
  logic              bad_d;

  logic                wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [VRAM_BPP-1:0] wr_data_d;
  logic                fs_d;
  logic                fd_d;
  logic                le_d;
  logic                pe_d;
  logic                locked_d;

  logic vs_edge;
  logic hs_edge;
  logic active;

  video_color_decode #(
    .VRAM_BPP (VRAM_BPP)
  ) u_dec (
    .color (s1.color),
    .data  (dec_data),
    .mixed (dec_mixed)
  );

  assign vs_edge = !s1.vs_n && s2_vs_n;
  assign hs_edge = !s1.hs_n && s2_hs_n;

  // A line still open at frame close counts toward the line total.
  assign y_fin = (cnt != '0 && y != Y_END)
               ? y + YW'(1) : y;

  // Input sampling and the delayed sync copy used for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1      <= '0;
      s2_hs_n <= 1'b0;
      s2_vs_n <= 1'b0;
    end else begin
      s1.en    <= enable;
      s1.de    <= video_de;
      s1.hs_n  <= video_hsyncn;
      s1.vs_n  <= video_vsyncn;
      s1.color <= video_color;
      s2_hs_n  <= s1.hs_n;
      s2_vs_n  <= s1.vs_n;
    end
  end

  // Next state, counters and strobes; vsync, then hsync, then pixel.
  always_comb begin
    state_d   = state;
    x_d       = x;
    y_d       = y;
    cnt_d     = cnt;
    base_d    = base;
    bad_d     = bad;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    fs_d      = 1'b0;
    fd_d      = 1'b0;
    le_d      = 1'b0;
    pe_d      = 1'b0;
    locked_d  = locked;
    active    = (state == CAPTURE);

    if (vs_edge) begin
      if (active) begin
        fd_d     = 1'b1;
        locked_d = (y_fin == Y_END) && !bad;
      end
      if (s1.en) begin
        state_d = CAPTURE;
        active  = 1'b1;
        fs_d    = 1'b1;
        x_d     = '0;
        y_d     = '0;
        cnt_d   = '0;
        base_d  = '0;
        bad_d   = 1'b0;
      end else begin
        state_d = IDLE;
        active  = 1'b0;
      end
    end

    if (active && hs_edge && cnt_d != '0) begin
      if (cnt_d != C_LINE) begin
        le_d  = 1'b1;
        bad_d = 1'b1;
      end
      if (y_d != Y_END) begin
        y_d    = y_d + YW'(1);
        base_d = base_d + A_STEP;
      end
      x_d   = '0;
      cnt_d = '0;
    end

    if (active && s1.de) begin
      if (x_d != X_END && y_d != Y_END) begin
        wr_en_d   = 1'b1;
        wr_addr_d = base_d + ADDR_W'(x_d);
        wr_data_d = dec_data;
        pe_d      = dec_mixed;
        if (dec_mixed) begin
          bad_d = 1'b1;
        end
      end else begin
        bad_d = 1'b1;
      end
      if (x_d != X_END) begin
        x_d = x_d + XW'(1);
      end
      if (cnt_d != C_MAX) begin
        cnt_d = cnt_d + CW'(1);
      end
    end
  end

  // Capture FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Raster position, line base and frame health.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x    <= '0;
      y    <= '0;
      cnt  <= '0;
      base <= '0;
      bad  <= 1'b0;
    end else begin
      x    <= x_d;
      y    <= y_d;
      cnt  <= cnt_d;
      base <= base_d;
      bad  <= bad_d;
    end
  end

  // Registered write port and status strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      pix_err     <= 1'b0;
      locked      <= 1'b0;
    end else begin
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      frame_start <= fs_d;
      frame_done  <= fd_d;
      line_err    <= le_d;
      pix_err     <= pe_d;
      locked      <= locked_d;
    end
  end

endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: table-driven check of video_capture at 4x3.
// Row outputs are compared two clocks after the row's inputs.
module tb_video_capture;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int BPP = 3;
  localparam int AW  = 4;

  localparam bit F = 1'b0;
  localparam bit T = 1'b1;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           enable = 1'b0;
  logic           video_de = 1'b0;
  logic           video_hsyncn = 1'b1;
  logic           video_vsyncn = 1'b1;
  logic [35:0]    video_color = '0;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [BPP-1:0] wr_data;
  logic           frame_start;
  logic           frame_done;
  logic           line_err;
  logic           pix_err;
  logic           locked;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic           de, hs, vs, en;
    logic [35:0]    color;
    logic           wr;
    logic [AW-1:0]  addr;
    logic [BPP-1:0] data;
    logic           fs, fd, le, pe, lk;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  video_capture #(
    .WIDTH    (W),
    .HEIGHT   (H),
    .VRAM_BPP (BPP),
    .ADDR_W   (AW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .video_de     (video_de),
    .video_hsyncn (video_hsyncn),
    .video_vsyncn (video_vsyncn),
    .video_color  (video_color),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .line_err     (line_err),
    .pix_err      (pix_err),
    .locked       (locked)
  );

  function automatic logic [35:0] enc(input int v);
    logic [2:0] c;
    c = 3'(v);
    return {{12{c[0]}}, {12{c[2]}}, {12{c[1]}}};
  endfunction

  function automatic vec_t mk(
    input logic wr, input int a, input int d,
    input logic fs, input logic fd, input logic le,
    input logic pe, input logic lk
  );
    vec_t v;
    v.de = 1'b0; v.hs = 1'b1; v.vs = 1'b1; v.en = 1'b0;
    v.color = '0;
    v.wr = wr; v.addr = AW'(a); v.data = BPP'(d);
    v.fs = fs; v.fd = fd; v.le = le; v.pe = pe; v.lk = lk;
    return v;
  endfunction

  task automatic add(
    input logic de, input logic hs, input logic vs,
    input logic en, input logic [35:0] c,
    input logic wr, input int a, input int d,
    input logic fs, input logic fd, input logic le,
    input logic pe, input logic lk
  );
    vec_t v;
    v = mk(wr, a, d, fs, fd, le, pe, lk);
    v.de = de; v.hs = hs; v.vs = vs; v.en = en; v.color = c;
    vq.push_back(v);
  endtask

  task automatic idle(input int n, input logic en, input logic lk);
    for (int i = 0; i < n; i++)
      add(F, T, T, en, '0, F, 0, 0, F, F, F, F, lk);
  endtask

  task automatic vsync(
    input logic de, input logic en, input int cv,
    input logic fs, input logic fd, input logic lk,
    input logic wr
  );
    add(de, T, F, en, enc(cv), wr, 0, cv, fs, fd, F, F, lk);
  endtask

  // hsync row (le = expected line_err of the line it closes), then pixels
  task automatic line(
    input int y, input int n, input logic en,
    input logic lk, input logic le, input logic wr
  );
    add(F, F, T, en, '0, F, 0, 0, F, F, le, F, lk);
    for (int k = 0; k < n; k++) begin
      int a;
      a = y * W + k;
      add(T, T, T, en, enc(a % 8), wr && (k < W), a, a % 8,
          F, F, F, F, lk);
    end
  endtask

  task automatic drive(input vec_t v);
    video_de     = v.de;
    video_hsyncn = v.hs;
    video_vsyncn = v.vs;
    enable       = v.en;
    video_color  = v.color;
  endtask

  task automatic chk(input string name, input vec_t w);
    logic ok;
    checks++;
    ok = (wr_en === w.wr) && (frame_start === w.fs)
      && (frame_done === w.fd) && (line_err === w.le)
      && (pix_err === w.pe) && (locked === w.lk);
    if (w.wr)
      ok = ok && (wr_addr === w.addr) && (wr_data === w.data);
    if (!ok) begin
      errors++;
      $display("FAIL %s: got wr=%b a=%0d d=%0d fs=%b fd=%b le=%b pe=%b lk=%b want wr=%b a=%0d d=%0d fs=%b fd=%b le=%b pe=%b lk=%b",
        name, wr_en, wr_addr, wr_data, frame_start, frame_done,
        line_err, pix_err, locked, w.wr, w.addr, w.data,
        w.fs, w.fd, w.le, w.pe, w.lk);
    end
  endtask

  task automatic chk_zero(input string name);
    logic [AW+BPP+5:0] got;
    got = {wr_en, wr_addr, wr_data, frame_start, frame_done,
           line_err, pix_err, locked};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL %s: got outputs=%b want all zero", name, got);
    end
  endtask

  initial begin
    // frame 1: clean, colour i mod 8
    idle(3, T, F);
    vsync(F, T, 0, T, F, F, F);
    line(0, 4, T, F, F, T);
    line(1, 4, T, F, F, T);
    line(2, 4, T, F, F, T);
    idle(1, T, F);
    // frame 2: line 1 has 5 DE cycles
    vsync(F, T, 0, T, T, T, F);
    line(0, 4, T, T, F, T);
    line(1, 5, T, T, F, T);
    line(2, 4, T, T, T, T);
    idle(1, T, T);
    // frame 3: clean again
    vsync(F, T, 0, T, T, F, F);
    line(0, 4, T, F, F, T);
    line(1, 4, T, F, F, T);
    line(2, 4, T, F, F, T);
    idle(1, T, F);
    // frame 4: one mixed field at addr 1
    vsync(F, T, 0, T, T, T, F);
    add(F, F, T, T, '0, F, 0, 0, F, F, F, F, T);
    add(T, T, T, T, enc(0), T, 0, 0, F, F, F, F, T);
    add(T, T, T, T, {12'hFFF, 12'h0F0, 12'hFFF},
        T, 1, 3, F, F, F, T, T);
    add(T, T, T, T, enc(2), T, 2, 2, F, F, F, F, T);
    add(T, T, T, T, enc(3), T, 3, 3, F, F, F, F, T);
    line(1, 4, T, T, F, T);
    line(2, 4, T, T, F, T);
    idle(1, T, T);
    // close with enable=0, then a disabled frame
    vsync(F, F, 0, F, T, F, F);
    idle(2, F, F);
    line(0, 4, F, F, F, F);
    line(1, 4, T, F, F, F);
    idle(1, T, F);
    // DE coincident with vsync lands at addr 0
    vsync(T, T, 5, T, F, F, T);
    for (int k = 1; k < 4; k++)
      add(T, T, T, T, enc(k), T, k, k, F, F, F, F, F);
    line(1, 4, T, F, F, T);
    line(2, 4, T, F, F, T);
    idle(1, T, F);
    vsync(F, T, 0, T, T, T, F);
    idle(2, T, T);

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_state");
    resetn = 1'b1;

    for (int i = 0; i <= vq.size(); i++) begin
      if (i < vq.size()) drive(vq[i]);
      else drive(mk(F, 0, 0, F, F, F, F, F));
      @(posedge clk);
      #1;
      if (i > 0) chk($sformatf("row%0d", i - 1), vq[i - 1]);
    end

    // reset mid-line while writes are flowing
    enable = 1'b1;
    video_hsyncn = 1'b0;
    video_de = 1'b0;
    @(posedge clk);
    #1;
    video_hsyncn = 1'b1;
    video_de = 1'b1;
    video_color = enc(7);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_reset", mk(T, 0, 7, F, F, F, F, T));
    #2;
    resetn = 1'b0;
    #1;
    chk_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      video_hsyncn = (i == 2) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("no_write_%0d", i),
          mk(F, 0, 0, F, F, F, F, F));
    end
    video_hsyncn = 1'b1;
    video_vsyncn = 1'b0;
    video_color = enc(6);
    @(posedge clk);
    #1;
    video_vsyncn = 1'b1;
    video_color = enc(1);
    @(posedge clk);
    #1;
    chk("restart", mk(T, 0, 6, T, F, F, F, F));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_capture.md
# video_capture

Receive-side counterpart of the SoC video output: samples the DE / active-low sync / 36-bit replicated-colour stream, decodes each pixel back to VRAM_BPP bits, and writes it into a framebuffer write port at its raster address. It is used for loopback self-test of the video path and as a frame-grab path into on-chip RAM. It runs in a single clock domain; the video source must be synchronous to `clk`.

## Interface
- WIDTH, 640, active pixels per line
- HEIGHT, 480, active lines per frame
- VRAM_BPP, 3, decoded bits per pixel
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- clk  in  1  sole clock
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  arm capture; sampled only at frame start
- video_de  in  1  data enable
- video_hsyncn  in  1  horizontal sync, active low
- video_vsyncn  in  1  vertical sync, active low
- video_color  in  36  {12×c[0], 12×c[2], 12×c[1]}
- wr_en  out  1  framebuffer write strobe
- wr_addr  out  ADDR_W  y*WIDTH + x
- wr_data  out  VRAM_BPP  decoded pixel
- frame_start  out  1  one-cycle pulse on accepted vsync assertion
- frame_done  out  1  one-cycle pulse when a captured frame closes
- line_err  out  1  one-cycle pulse: closed line had DE count ≠ WIDTH
- pix_err  out  1  one-cycle pulse with wr_en: some 12-bit field not all-0/all-1
- locked  out  1  last captured frame was exactly HEIGHT lines of WIDTH pixels with no errors

## Operation
- Stage 1 registers all video inputs. Stage 2 holds a delayed copy of the stage 1 values for edge detection.
- vsync assertion means stage-1 vsyncn=0 and stage-2 vsyncn=1. hsync assertion is detected the same way.
- Decode: c[0]=color[35], c[2]=color[23], c[1]=color[11] (MSB of each field). pix_err is set if any field is mixed.
- States:
  - IDLE to CAPTURE on vsync assertion with enable=1: pulse frame_start, x=0, y=0, line_base=0, pixels-in-line=0.
  - CAPTURE to CAPTURE on vsync assertion: close the frame (frame_done, update locked), then restart as above if enable=1, otherwise go to IDLE.
  - In IDLE, vsync assertion with enable=0 does nothing.
- In CAPTURE, each stage-1 DE=1 cycle produces one pixel:
  - If x<WIDTH and y<HEIGHT: wr_en=1, wr_addr=line_base+x.
  - Otherwise the pixel is dropped and the frame is marked bad.
  - x increments, saturating at WIDTH.
- hsync assertion in CAPTURE:
  - If the line had ≥1 pixel: line_err pulses if the count ≠ WIDTH; y++ (saturating at HEIGHT); line_base += WIDTH; x=0.
  - Lines with no DE (blanking) are ignored.
- No multiplier is used: the address comes from the running line_base plus x.
- locked at frame close = (y==HEIGHT, counting a final line not yet closed by hsync) AND no line_err, pix_err or dropped pixel in the frame. Otherwise locked=0.
- Simultaneous events resolve in this order: vsync, then hsync, then pixel. A DE pixel coincident with frame start lands at address 0; one coincident with an hsync line close lands at x=0 of the new line.

## Timing
- Reset: every output is 0, state is IDLE, all counters are 0. After reset, capture resumes only at the next vsync assertion.
- Latency: input sample to wr_en/wr_addr/wr_data/pix_err is exactly 2 clk cycles. frame_start, frame_done and line_err are also asserted 2 cycles after the sync edge reaches the inputs.
- One write per clk at full rate; no backpressure. The framebuffer must accept a write every cycle.
- locked changes only in the frame_done cycle.
- Counters never wrap: x saturates at WIDTH and y at HEIGHT.

## Structure
- Package `video_capture_pkg`: state encoding (IDLE, CAPTURE), colour field bit positions (35, 23, 11), field width 12.
- Sub-module `video_color_decode`: 36-bit field → VRAM_BPP bits plus the mixed-field flag. Purely combinational, instantiated before the stage-2 register.
- All else lives in the top module: sync edge detect, counters and FSM.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3.
- Clean frame, colour pattern c=i mod 8, enable=1: 12 writes at addr 0..11 with wr_data=i mod 8. frame_done at the next vsync with locked=1, no error pulses.
- Line 1 with 5 DE cycles: 5th pixel dropped (no write), line_err at hsync, locked=0 at frame close; the next clean frame restores locked=1.
- color[23:12]=0x0F0 for one pixel: pix_err pulses with that write and wr_data[2]=0; locked=0.
- enable=0 at vsync: no writes, frame_start or frame_done for that frame; raising enable mid-frame has no effect until the next vsync.
- DE=1 coincident with vsync assertion: frame_start and a write to addr 0 in the same cycle, 2 cycles after the input.
- Deassert resetn mid-line: all outputs go 0 immediately; after release, no writes until vsync, then capture starts at addr 0.
